// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store sequencer for a byte-addressed, big-endian,
//                word-wide data RAM. Aligns and extends loads and performs
//                SB/SH as read-modify-write of the containing word.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
   parameter int MEM_BYTES = 61
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Req,
   input  logic [3:0]  Op,
   input  logic [31:0] Addr,
   input  logic [31:0] StoreData,
   output logic        Busy,
   output logic        Done,
   output logic        Err,
   output logic [31:0] LoadData,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWriteData,
   output logic        MemnRD,
   output logic        MemnWR,
   input  logic [31:0] MemDataIn
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WR   = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   state_t      state, state_next;

   // Latched request; the RAM side is driven only from these and the state.
   logic [3:0]  op_q;
   logic [29:0] word_q;
   logic [1:0]  off_q;
   logic [15:0] sdata_q;
   logic [31:0] wword_q;
   logic [31:0] load_q;

   logic        illegal;
   logic        is_sw;
   logic [32:0] last_byte;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_ext;
   logic [31:0] merged;

   // Legality of the incoming request, evaluated at accept time
   always_comb begin
      last_byte = {1'b0, Addr[31:2], 2'b00} + 33'd3;
      illegal   = (Op[1:0] == 2'b11)
                | ((Op[1:0] == 2'b01) && Addr[0])
                | ((Op[1:0] == 2'b10) && (Addr[1:0] != 2'b00))
                | (last_byte > 33'(MEM_BYTES - 1));
      is_sw     = Op[3] && (Op[1:0] == 2'b10);
   end

   // State register
   always_ff @(posedge CLK) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Next-state decode
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (Req) begin
               if (illegal)    state_next = ST_ERR;
               else if (is_sw) state_next = ST_WR;
               else            state_next = ST_RD;
            end
         end
         ST_RD:   state_next = op_q[3] ? ST_WR : ST_DONE;
         ST_WR:   state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         ST_ERR:  state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Lane extraction, extension and sub-word merge from the read word (big-endian)
   always_comb begin
      byte_lane = 8'h00;
      case (off_q)
         2'd0: byte_lane = MemDataIn[31:24];
         2'd1: byte_lane = MemDataIn[23:16];
         2'd2: byte_lane = MemDataIn[15:8];
         2'd3: byte_lane = MemDataIn[7:0];
         default: byte_lane = 8'h00;
      endcase
      half_lane = off_q[1] ? MemDataIn[15:0] : MemDataIn[31:16];

      case (op_q[1:0])
         2'b00:   load_ext = op_q[2] ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
         2'b01:   load_ext = op_q[2] ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
         default: load_ext = MemDataIn;
      endcase

      merged = MemDataIn;
      if (op_q[1:0] == 2'b00) begin
         case (off_q)
            2'd0: merged[31:24] = sdata_q[7:0];
            2'd1: merged[23:16] = sdata_q[7:0];
            2'd2: merged[15:8]  = sdata_q[7:0];
            2'd3: merged[7:0]   = sdata_q[7:0];
            default: merged = MemDataIn;
         endcase
      end else if (off_q[1]) begin
         merged[15:0]  = sdata_q;
      end else begin
         merged[31:16] = sdata_q;
      end
   end

   // Request capture at accept; load result or merged word at the end of RD
   always_ff @(posedge CLK) begin
      if (Reset) begin
         op_q    <= 4'h0;
         word_q  <= 30'h0;
         off_q   <= 2'd0;
         sdata_q <= 16'h0;
         wword_q <= 32'h0;
         load_q  <= 32'h0;
      end else begin
         if (state == ST_IDLE && Req) begin
            op_q    <= Op;
            word_q  <= Addr[31:2];
            off_q   <= Addr[1:0];
            sdata_q <= StoreData[15:0];
            wword_q <= StoreData;
         end
         if (state == ST_RD) begin
            if (op_q[3]) wword_q <= merged;
            else         load_q  <= load_ext;
         end
      end
   end

   // Status and RAM-side outputs decoded from state and latched request only
   always_comb begin
      Busy         = (state != ST_IDLE);
      Done         = (state == ST_DONE) || (state == ST_ERR);
      Err          = (state == ST_ERR);
      LoadData     = load_q;
      MemAddr      = 32'h0;
      MemWriteData = 32'h0;
      MemnRD       = 1'b1;
      MemnWR       = 1'b1;
      if (state == ST_RD) begin
         MemAddr = {word_q, 2'b00};
         MemnRD  = 1'b0;
      end else if (state == ST_WR) begin
         MemAddr      = {word_q, 2'b00};
         MemWriteData = wword_q;
         MemnWR       = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Directed, table-driven bench for mem_access_unit with a
//                byte-array big-endian RAM model that commits on negedge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

   localparam int MEM_BYTES = 61;

   logic        CLK = 1'b0;
   logic        Reset, Req;
   logic [3:0]  Op;
   logic [31:0] Addr, StoreData;
   logic        Busy, Done, Err;
   logic [31:0] LoadData, MemAddr, MemWriteData, MemDataIn;
   logic        MemnRD, MemnWR;

   logic [7:0]  mem [0:MEM_BYTES-1];

   int total = 0;
   int bad   = 0;

   // Per-access observations
   int          n_rd, n_wr, n_done, n_err, done_idx, both_low;
   logic [31:0] rd_addr, wr_addr, wr_data;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] sd;
      logic [31:0] exp_load;
      logic        exp_err;
      int          exp_done;
      int          exp_rd;
      int          exp_wr;
      logic [31:0] exp_base;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t vecs [15];

   mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .CLK(CLK), .Reset(Reset), .Req(Req), .Op(Op), .Addr(Addr),
      .StoreData(StoreData), .Busy(Busy), .Done(Done), .Err(Err),
      .LoadData(LoadData), .MemAddr(MemAddr), .MemWriteData(MemWriteData),
      .MemnRD(MemnRD), .MemnWR(MemnWR), .MemDataIn(MemDataIn)
   );

   always #5 CLK = ~CLK;

   // RAM read port: combinational word at MemAddr
   always_comb begin
      MemDataIn = 32'h0;
      if (MemAddr + 32'd3 < 32'(MEM_BYTES))
         MemDataIn = {mem[MemAddr], mem[MemAddr+1], mem[MemAddr+2], mem[MemAddr+3]};
   end

   // RAM write port: commits at negedge while MemnWR is low
   always @(negedge CLK) begin
      if (!MemnWR && (MemAddr + 32'd3 < 32'(MEM_BYTES))) begin
         mem[MemAddr]   <= MemWriteData[31:24];
         mem[MemAddr+1] <= MemWriteData[23:16];
         mem[MemAddr+2] <= MemWriteData[15:8];
         mem[MemAddr+3] <= MemWriteData[7:0];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Issue one request and observe 8 cycles from the accept edge onward
   task automatic run_access(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd);
      Op = op; Addr = a; StoreData = sd; Req = 1'b1;
      @(posedge CLK); #1;
      Req = 1'b0;
      n_rd = 0; n_wr = 0; n_done = 0; n_err = 0; done_idx = -1; both_low = 0;
      rd_addr = 32'hx; wr_addr = 32'hx; wr_data = 32'hx;
      for (int c = 0; c < 8; c++) begin
         if (!MemnRD) begin n_rd++; rd_addr = MemAddr; end
         if (!MemnWR) begin n_wr++; wr_addr = MemAddr; wr_data = MemWriteData; end
         if (!MemnRD && !MemnWR) both_low++;
         if (Done) begin n_done++; if (done_idx < 0) done_idx = c; end
         if (Err) n_err++;
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
      mem[8] = 8'h88; mem[9] = 8'h99; mem[10] = 8'hAA; mem[11] = 8'hBB;

      //           op       addr   sd            load          err   done rd wr base   wdata
      vecs[0]  = '{4'b0000, 32'd9,  32'h0,        32'hFFFFFF99, 1'b0, 1, 1, 0, 32'd8,  32'h0};
      vecs[1]  = '{4'b0100, 32'd9,  32'h0,        32'h00000099, 1'b0, 1, 1, 0, 32'd8,  32'h0};
      vecs[2]  = '{4'b0001, 32'd10, 32'h0,        32'hFFFFAABB, 1'b0, 1, 1, 0, 32'd8,  32'h0};
      vecs[3]  = '{4'b0101, 32'd10, 32'h0,        32'h0000AABB, 1'b0, 1, 1, 0, 32'd8,  32'h0};
      vecs[4]  = '{4'b0010, 32'd8,  32'h0,        32'h8899AABB, 1'b0, 1, 1, 0, 32'd8,  32'h0};
      vecs[5]  = '{4'b1000, 32'd11, 32'h12345677, 32'h8899AABB, 1'b0, 2, 1, 1, 32'd8,  32'h8899AA77};
      vecs[6]  = '{4'b0010, 32'd8,  32'h0,        32'h8899AA77, 1'b0, 1, 1, 0, 32'd8,  32'h0};
      vecs[7]  = '{4'b1001, 32'd8,  32'h0000CAFE, 32'h8899AA77, 1'b0, 2, 1, 1, 32'd8,  32'hCAFEAA77};
      vecs[8]  = '{4'b0010, 32'd8,  32'h0,        32'hCAFEAA77, 1'b0, 1, 1, 0, 32'd8,  32'h0};
      vecs[9]  = '{4'b1010, 32'd12, 32'hDEADBEEF, 32'hCAFEAA77, 1'b0, 1, 0, 1, 32'd12, 32'hDEADBEEF};
      vecs[10] = '{4'b0010, 32'd12, 32'h0,        32'hDEADBEEF, 1'b0, 1, 1, 0, 32'd12, 32'h0};
      vecs[11] = '{4'b0001, 32'd9,  32'h0,        32'hDEADBEEF, 1'b1, 0, 0, 0, 32'd0,  32'h0};
      vecs[12] = '{4'b0010, 32'd10, 32'h0,        32'hDEADBEEF, 1'b1, 0, 0, 0, 32'd0,  32'h0};
      vecs[13] = '{4'b0010, 32'd60, 32'h0,        32'hDEADBEEF, 1'b1, 0, 0, 0, 32'd0,  32'h0};
      vecs[14] = '{4'b0011, 32'd8,  32'h0,        32'hDEADBEEF, 1'b1, 0, 0, 0, 32'd0,  32'h0};

      Reset = 1'b1; Req = 1'b0; Op = 4'h0; Addr = 32'h0; StoreData = 32'h0;
      repeat (3) @(posedge CLK);
      #1 Reset = 1'b0;

      check("reset_busy",   {31'h0, Busy},   32'h0);
      check("reset_done",   {31'h0, Done},   32'h0);
      check("reset_err",    {31'h0, Err},    32'h0);
      check("reset_load",   LoadData,        32'h0);
      check("reset_maddr",  MemAddr,         32'h0);
      check("reset_mwdata", MemWriteData,    32'h0);
      check("reset_nrd",    {31'h0, MemnRD}, 32'h1);
      check("reset_nwr",    {31'h0, MemnWR}, 32'h1);

      for (int v = 0; v < 15; v++) begin
         run_access(vecs[v].op, vecs[v].addr, vecs[v].sd);
         check($sformatf("v%0d_load", v),     LoadData,                vecs[v].exp_load);
         check($sformatf("v%0d_done_at", v),  32'(done_idx),           32'(vecs[v].exp_done));
         check($sformatf("v%0d_ndone", v),    32'(n_done),             32'd1);
         check($sformatf("v%0d_nerr", v),     32'(n_err),              {31'h0, vecs[v].exp_err});
         check($sformatf("v%0d_nrd", v),      32'(n_rd),               32'(vecs[v].exp_rd));
         check($sformatf("v%0d_nwr", v),      32'(n_wr),               32'(vecs[v].exp_wr));
         check($sformatf("v%0d_bothlow", v),  32'(both_low),           32'd0);
         if (vecs[v].exp_rd != 0)
            check($sformatf("v%0d_rdaddr", v), rd_addr, vecs[v].exp_base);
         if (vecs[v].exp_wr != 0) begin
            check($sformatf("v%0d_wraddr", v), wr_addr, vecs[v].exp_base);
            check($sformatf("v%0d_wrdata", v), wr_data, vecs[v].exp_wdata);
         end
      end

      // Reset pulsed during the RD cycle of an SB: no write, reset values next cycle
      Op = 4'b1000; Addr = 32'd8; StoreData = 32'h00000055; Req = 1'b1;
      @(posedge CLK); #1;
      Req = 1'b0;
      check("rst_rd_phase", {31'h0, MemnRD}, 32'h0);
      Reset = 1'b1;
      @(posedge CLK); #1;
      Reset = 1'b0;
      check("rst_busy",   {31'h0, Busy},   32'h0);
      check("rst_done",   {31'h0, Done},   32'h0);
      check("rst_err",    {31'h0, Err},    32'h0);
      check("rst_load",   LoadData,        32'h0);
      check("rst_maddr",  MemAddr,         32'h0);
      check("rst_mwdata", MemWriteData,    32'h0);
      check("rst_nrd",    {31'h0, MemnRD}, 32'h1);
      check("rst_nwr",    {31'h0, MemnWR}, 32'h1);
      n_done = 0;
      for (int c = 0; c < 4; c++) begin
         if (Done || !MemnWR) n_done++;
         @(posedge CLK); #1;
      end
      check("rst_no_activity", 32'(n_done), 32'd0);
      check("rst_mem_word8", {mem[8], mem[9], mem[10], mem[11]}, 32'hCAFEAA77);

      // Req toggled while busy: exactly one completion
      Op = 4'b0010; Addr = 32'd12; Req = 1'b1;
      @(posedge CLK); #1;
      n_done = 0;
      for (int c = 0; c < 8; c++) begin
         if (Done) begin
            n_done++;
            Req = 1'b0;
         end else if (Busy) begin
            Req = ~Req;
         end else begin
            Req = 1'b0;
         end
         @(posedge CLK); #1;
      end
      check("toggle_ndone", 32'(n_done), 32'd1);
      check("toggle_load",  LoadData,    32'hDEADBEEF);
      check("toggle_idle",  {31'h0, Busy}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global time limit
   initial begin
      #100000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store sequencer between the CPU datapath (upstream) and the byte-addressed, big-endian data RAM (downstream).
- Accepts one LB/LBU/LH/LHU/LW/SB/SH/SW request at a time and drives the RAM's active-low read/write port.
- Aligns and sign- or zero-extends load data.
- Implements SB/SH as a read-modify-write of the containing word, because the RAM only writes whole words.

Parameters:
MEM_BYTES, 61, RAM size in bytes; the aligned word base must satisfy base+3 <= MEM_BYTES-1.

Ports:
CLK  in  1  clock; all state updates on posedge
Reset  in  1  synchronous, active-high reset
Req  in  1  access request; sampled only in IDLE
Op  in  4  [3]=store, [2]=unsigned (loads only), [1:0]=size: 00 byte, 01 half, 10 word, 11 illegal
Addr  in  32  byte address
StoreData  in  32  store operand; low byte/half used for SB/SH
Busy  out  1  high in every state except IDLE
Done  out  1  one-cycle completion pulse (also on error)
Err  out  1  one-cycle pulse with Done for illegal access
LoadData  out  32  extended load result; holds until next successful load
MemAddr  out  32  word-aligned RAM address
MemWriteData  out  32  word to RAM
MemnRD  out  1  active-low RAM read enable
MemnWR  out  1  active-low RAM write enable (RAM commits at negedge)
MemDataIn  in  32  combinational RAM read data

Behaviour:
- Reset values: state=IDLE, Busy=0, Done=0, Err=0, LoadData=0, MemAddr=0, MemWriteData=0, MemnRD=1, MemnWR=1.
- Memory-side outputs are decoded from the state register and latched request registers only. No combinational path from Req/Addr to the Mem* outputs.
- Big-endian lanes:
  - Byte offset o=Addr[1:0] selects bits [31-8o:24-8o].
  - Half at offset 0 selects [31:16]; half at offset 2 selects [15:0].
  - Aligned base = {Addr[31:2],2'b00}.
- Illegal request (checked at accept): size 11; half with Addr[0]=1; word with Addr[1:0]!=00; base+3 > MEM_BYTES-1.
- FSM: IDLE, RD, WR, DONE, ERR.
- IDLE: on Req=1, latch Op/Addr/StoreData, then go to:
  - ERR if illegal;
  - WR for SW;
  - RD otherwise.
- RD: MemnRD=0, MemAddr=base.
  - At the closing posedge, loads register LoadData (byte/half extracted, sign-extended unless Op[2]=1; word passed through) and go to DONE.
  - SB/SH register the merged word (read word with the target lane replaced by StoreData[7:0] / [15:0]) and go to WR.
- WR: MemnWR=0, MemAddr=base, MemWriteData = merged word (SB/SH) or StoreData (SW). Next state is DONE.
- DONE: Done=1 for one cycle, then IDLE.
- ERR: Done=1 and Err=1 for one cycle, then IDLE. No RAM access; LoadData unchanged.
- Outside RD/WR: MemAddr=0, MemWriteData=0, MemnRD=1, MemnWR=1. MemnRD and MemnWR are never low together.
- Latency, with request accepted at posedge k:
  - loads and SW: Done high in cycle k+1..k+2;
  - SB/SH: Done high in cycle k+2..k+3;
  - errors: Done high in cycle k..k+1.
- Req while Busy=1 is ignored; there is no queue.
- If Req is still high in IDLE after Done, a new access starts. Upstream deasserts Req on Done.
- Reset mid-operation: the next posedge returns to reset values. Any RAM access in the current cycle completes (a WR-cycle negedge write still commits). A reset asserted during RD of SB/SH leaves memory unchanged.
- Back-to-back: IDLE is mandatory between accesses; minimum 3 cycles per load/SW, 4 per SB/SH.

Test Plan:
- Preload bytes 8..11 = 88 99 AA BB.
  - LB Addr=9 -> LoadData=0xFFFFFF99.
  - LBU Addr=9 -> 0x00000099.
  - Each load: exactly one MemnRD-low cycle with MemAddr=8; Done two cycles after accept.
- LH Addr=10 -> 0xFFFFAABB; LHU Addr=10 -> 0x0000AABB; LW Addr=8 -> 0x8899AABB.
- SB Addr=11 StoreData=0x12345677 -> one RD cycle, then one WR cycle with MemWriteData=0x8899AA77; LW 8 -> 0x8899AA77.
- SH Addr=8 StoreData=0x0000CAFE -> word 0xCAFEAA77.
- SW Addr=12 0xDEADBEEF -> no MemnRD cycle, Done at k+2; LW 12 -> 0xDEADBEEF.
- LH Addr=9, LW Addr=10, LW Addr=60, Op size=11:
  - each gives Err=Done=1 one cycle after accept;
  - MemnRD/MemnWR stay 1; LoadData unchanged.
- SB Addr=8 with Reset pulsed during RD: next cycle all outputs at reset values and word 8 unchanged.
- Req toggled while Busy=1: ignored, only one Done per accepted request.
